loadable_down_counter: RTL and testbench
========================================

// Module: loadable_down_counter
// PURPOSE
//   Loadable down-counter/timer with asynchronous reset; the count-down counterpart to the free-running up counter.
//   Software or an FSM loads a start value, counts down on enable, and is told when zero is reached.
//   Used for delay generation, timeouts and event countdowns.
//   Exports a terminal-count pulse and level status (busy/done) for downstream control logic.
// PARAMETERS
//   WIDTH      3   counter width in bits; legal range 2..32
// PORTS
//   clk        in   1      clock; all state changes on posedge clk
//   rst        in   1      reset, asynchronous, active-high
//   clr        in   1      synchronous clear: q<=0, state->IDLE
//   load       in   1      load strobe: capture load_val and start counting
//   load_val   in   WIDTH  start value sampled when load=1
//   en         in   1      count enable: one decrement per cycle while RUN
//   q          out  WIDTH  current count (registered)
//   busy       out  1      1 while state==RUN
//   done       out  1      1 while state==DONE (level)
//   tc         out  1      terminal-count pulse: high exactly one cycle, in the cycle q first reads 0
// BEHAVIOUR
//   - Reset: rst=1 forces state=IDLE, q=0, busy=0, done=0, tc=0 immediately; these values hold while rst=1.
//   - Reset mid-count aborts the count; no tc is generated.
//   - FSM states IDLE/RUN/DONE; busy and done decode directly from state (no added latency).
//   - Priority order each cycle: clr > load > en.
//   - clr: q<=0; state<=IDLE; tc<=0.
//   - load, load_val!=0: q<=load_val; state<=RUN. Legal from any state, including mid-count (restart).
//   - load, load_val==0: q<=0; state<=DONE; tc stays 0.
//   - load and en in the same cycle: load wins; no decrement.
//   - RUN, en=1, q>1: q<=q-1.
//   - RUN, en=1, q==1: q<=0; state<=DONE; tc<=1 for the next cycle only.
//   - RUN, en=0: q and state hold; tc=0.
//   - IDLE or DONE: en is ignored; q holds; only clr or load leave the state.
//   - Latency: tc and done assert 1 cycle after the clock edge that samples en with q==1.
//   - Arithmetic: unsigned, modulo 2^WIDTH. q never underflows past 0 in any mode.
// CONFIGURATION
//   Macro DOWN_CTR_AUTORELOAD_EN selects between one-shot and periodic operation.
//   - Undefined (one-shot): behaviour as listed above.
//   - Defined (periodic):
//     - A WIDTH-bit reload register rl captures load_val on every load; rl resets to 0.
//     - In RUN with en=1 and q==0: q<=rl and state stays RUN.
//     - Countdown runs rl..0 repeatedly, so the period is rl+1 enabled cycles.
//     - tc pulses each time q transitions 1->0.
//     - DONE is entered only via load_val==0.
//     - clr also clears rl.
// TESTING
//   1. rst=1 asserted mid-count at q=4 -> q=0, busy=0, done=0, tc=0 before the next clk edge.
//   2. load=1, load_val=5, then en=1 held -> q=5,4,3,2,1,0; tc=1 only in the q=0 cycle; then done=1, busy=0, q holds 0.
//   3. load 6, en=0 for 2 cycles at q=3 -> q stays 3 and busy=1; resume en=1 -> 2,1,0.
//   4. At q=2, drive load=1, load_val=7 and en=1 in the same cycle -> q=7 next cycle, no tc.
//      Also: load_val=0 -> done=1 next cycle, tc never asserts.
//   5. At q=3, drive clr=1 with load=1 -> q=0, state IDLE; then en=1 for 4 cycles -> q stays 0, tc=0.
//   6. DOWN_CTR_AUTORELOAD_EN defined: load 2, en=1 held -> q=2,1,0,2,1,0,...; tc pulses each q=0; done stays 0.

Source files
------------

// File: rtl/loadable_down_counter.sv
// Loadable down-counter / timer with terminal-count pulse and busy/done status.
// Load a start value, count down one step per enabled cycle, and report zero.
// Optional feature macro: DOWN_CTR_AUTORELOAD_EN
//   undefined -> one-shot: reaching zero parks the counter in DONE
//   defined   -> periodic: reload from the value captured at the last load
module loadable_down_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_next;
  logic [WIDTH-1:0] q_next;
  logic             tc_next;

`ifdef DOWN_CTR_AUTORELOAD_EN
  logic [WIDTH-1:0] rl, rl_next;
`endif

  // State, count and terminal-count registers; reset aborts any count in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_next;
      q     <= q_next;
      tc    <= tc_next;
    end
  end

`ifdef DOWN_CTR_AUTORELOAD_EN
  // Reload value captured on every load; cleared with the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rl <= '0;
    else     rl <= rl_next;
  end
`endif

  // Next-state logic, priority clr > load > en.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch;
    // the tc default of 0 is what makes it a single-cycle pulse.
    state_next = state;
    q_next     = q;
    tc_next    = 1'b0;
`ifdef DOWN_CTR_AUTORELOAD_EN
    rl_next    = rl;
`endif

    if (clr) begin
      state_next = IDLE;
      q_next     = '0;
`ifdef DOWN_CTR_AUTORELOAD_EN
      rl_next    = '0;
`endif
    end else if (load) begin
`ifdef DOWN_CTR_AUTORELOAD_EN
      rl_next = load_val;
`endif
      if (load_val != '0) begin
        state_next = RUN;
        q_next     = load_val;
      end else begin
        // Loading zero finishes immediately without a terminal-count pulse.
        state_next = DONE;
        q_next     = '0;
      end
    end else if (state == RUN && en) begin
      if (q > ONE) begin
        q_next = q - ONE;
      end else if (q == ONE) begin
        q_next  = '0;
        tc_next = 1'b1;
`ifndef DOWN_CTR_AUTORELOAD_EN
        state_next = DONE;
`endif
      end else begin
        // q == 0 while running: periodic mode starts the next period; in
        // one-shot mode this is unreachable and simply settles in DONE.
`ifdef DOWN_CTR_AUTORELOAD_EN
        q_next = rl;
`else
        state_next = DONE;
`endif
      end
    end
  end

  // Status decodes straight from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_loadable_down_counter.sv
// Self-checking bench for loadable_down_counter: fixed vector table, directed
// corner sequences and randomized stimulus against a behavioural model.
// Honours DOWN_CTR_AUTORELOAD_EN so it matches whichever build it is paired with.
module tb_loadable_down_counter;

  localparam int W = 3;

`ifdef DOWN_CTR_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en = 1'b0;
  logic [W-1:0] q;
  logic         busy, done, tc;

  int total = 0;
  int bad   = 0;

  // Behavioural model: plain integers describing the observable status.
  int m_q, m_rl;
  bit m_busy, m_done, m_tc;

  typedef struct {
    logic         c;
    logic         l;
    logic [W-1:0] v;
    logic         e;
    logic [W-1:0] xq;
    logic         xb;
    logic         xd;
    logic         xt;
  } vec_t;

  vec_t tbl[$];

  loadable_down_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .q        (q),
    .busy     (busy),
    .done     (done),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q = 0; m_rl = 0; m_busy = 0; m_done = 0; m_tc = 0;
  endfunction

  // One clock edge of the specified behaviour.
  function automatic void model_step(bit c, bit l, int v, bit e);
    m_tc = 0;
    if (c) begin
      m_q = 0; m_busy = 0; m_done = 0; m_rl = 0;
    end else if (l) begin
      m_rl = v;
      if (v != 0) begin
        m_q = v; m_busy = 1; m_done = 0;
      end else begin
        m_q = 0; m_busy = 0; m_done = 1;
      end
    end else if (m_busy && e) begin
      if (m_q >= 2) begin
        m_q = m_q - 1;
      end else if (m_q == 1) begin
        m_q  = 0;
        m_tc = 1;
        if (!AUTO) begin
          m_busy = 0; m_done = 1;
        end
      end else if (AUTO) begin
        m_q = m_rl;
      end
    end
  endfunction

  task automatic compare_model(input string tag);
    check({tag, ".q"},    int'(q),    m_q);
    check({tag, ".busy"}, int'(busy), int'(m_busy));
    check({tag, ".done"}, int'(done), int'(m_done));
    check({tag, ".tc"},   int'(tc),   int'(m_tc));
  endtask

  // Drive one cycle of inputs away from the active edge, then check after it.
  task automatic step(input string tag, input bit c, input bit l,
                      input logic [W-1:0] v, input bit e);
    @(negedge clk);
    clr = c; load = l; load_val = v; en = e;
    @(posedge clk);
    model_step(c, l, int'(v), e);
    #1;
    compare_model(tag);
  endtask

  initial begin
    model_reset();

    // Reset state while rst is held.
    #12;
    check("rst.q", int'(q), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.tc", int'(tc), 0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table: load then count down with en held.
`ifdef DOWN_CTR_AUTORELOAD_EN
    tbl.push_back('{1'b0, 1'b1, 3'd2, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0});
`else
    tbl.push_back('{1'b0, 1'b1, 3'd5, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0});
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      clr = tbl[i].c; load = tbl[i].l; load_val = tbl[i].v; en = tbl[i].e;
      @(posedge clk);
      model_step(tbl[i].c, tbl[i].l, int'(tbl[i].v), tbl[i].e);
      #1;
      check($sformatf("vec%0d.q", i),    int'(q),    int'(tbl[i].xq));
      check($sformatf("vec%0d.busy", i), int'(busy), int'(tbl[i].xb));
      check($sformatf("vec%0d.done", i), int'(done), int'(tbl[i].xd));
      check($sformatf("vec%0d.tc", i),   int'(tc),   int'(tbl[i].xt));
    end

    // Asynchronous reset mid-count at q=4: outputs clear before the next edge.
    step("pre_rst", 1'b0, 1'b1, 3'd5, 1'b0);
    step("pre_rst", 1'b0, 1'b0, 3'd0, 1'b1);
    check("pre_rst.q4", int'(q), 4);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst.q", int'(q), 0);
    check("async_rst.busy", int'(busy), 0);
    check("async_rst.done", int'(done), 0);
    check("async_rst.tc", int'(tc), 0);
    model_reset();
    @(posedge clk);
    #1;
    compare_model("rst_hold");
    @(negedge clk);
    rst = 1'b0;

    // Pause: en low holds q and busy, then resume.
    step("pause", 1'b0, 1'b1, 3'd6, 1'b0);
    for (int i = 0; i < 3; i++) step("pause", 1'b0, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step("pause_hold", 1'b0, 1'b0, 3'd0, 1'b0);
      check("pause_hold.q3", int'(q), 3);
      check("pause_hold.busy1", int'(busy), 1);
    end
    for (int i = 0; i < 3; i++) step("resume", 1'b0, 1'b0, 3'd0, 1'b1);
    check("resume.tc_at_zero", int'(tc), 1);

    // Load wins over en mid-count; no tc.
    step("restart", 1'b0, 1'b1, 3'd4, 1'b0);
    step("restart", 1'b0, 1'b0, 3'd0, 1'b1);
    step("restart", 1'b0, 1'b0, 3'd0, 1'b1);
    step("restart", 1'b0, 1'b1, 3'd7, 1'b1);
    check("restart.q7", int'(q), 7);
    check("restart.no_tc", int'(tc), 0);

    // Loading zero goes straight to DONE with no tc, en has no effect.
    step("load0", 1'b0, 1'b1, 3'd0, 1'b1);
    check("load0.done", int'(done), 1);
    for (int i = 0; i < 3; i++) step("load0_idle", 1'b0, 1'b0, 3'd0, 1'b1);
    check("load0.no_tc", int'(tc), 0);

    // clr beats load at q=3; then en is ignored in IDLE.
    step("clr", 1'b0, 1'b1, 3'd5, 1'b0);
    step("clr", 1'b0, 1'b0, 3'd0, 1'b1);
    step("clr", 1'b0, 1'b0, 3'd0, 1'b1);
    step("clr", 1'b1, 1'b1, 3'd6, 1'b1);
    check("clr.q0", int'(q), 0);
    check("clr.idle", int'(busy | done), 0);
    for (int i = 0; i < 4; i++) step("clr_idle", 1'b0, 1'b0, 3'd0, 1'b1);
    check("clr_idle.q0", int'(q), 0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 500; i++) begin
      step("rand",
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 6) == 0,
           W'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
